scan_addr_gen: RTL and testbench
================================

# scan_addr_gen

Upstream driver for the 3-8 decoder (`decoder_3_8`, 74138-style: enabled when G=1, G2A=0, G2B=0). It steps a 3-bit select address through all eight outputs with a programmable dwell time per output. Between dwells it inserts a blanking interval, during which the decoder is disabled so the address never changes while an output is active. Typical use is scanning LED digits or a row matrix; C/B/A/G/G2A/G2B connect one-to-one to the decoder inputs.

## Interface
- DIV, 4: clock cycles each address is held with the decoder enabled; legal range 1..256.
- BLANK, 1: clock cycles the decoder is disabled between dwells; legal range 1..256.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scanning enable; 0 parks the block in IDLE with the address held.
- dir  in  1  advance direction: 0 counts up (7→0 wraps), 1 counts down (0→7 wraps).
- load  in  1  one-cycle request to jump to load_val.
- load_val  in  3  jump target address.
- C, B, A  out  1 each  select address, MSB to LSB; registered.
- G, G2A, G2B  out  1 each  decoder enables; registered.
- step  out  1  one-cycle pulse when the address advances naturally.
- wrap  out  1  one-cycle pulse coincident with step when the advance wrapped.

## Operation
- States:
  - IDLE: G=0, G2A=1, G2B=1.
  - ACTIVE: G=1, G2A=0, G2B=0.
  - BLANK: G=1, G2A=1, G2B=0.
- G2B is always 0 except in IDLE.
- Reset values:
  - state IDLE, address 0, so {C,B,A}=000.
  - G=0, G2A=1, G2B=1.
  - step=0, wrap=0, timer 0.
- Transitions, evaluated in priority order rst > load > en > timer:
  - IDLE→ACTIVE when en=1; the timer restarts for DIV cycles; the address is unchanged.
  - ACTIVE→BLANK after DIV cycles in ACTIVE. On this edge the address advances by ±1 mod 8 per the current dir, and step=1. wrap=1 if the move was 7→0 (up) or 0→7 (down).
  - BLANK→ACTIVE after BLANK cycles in BLANK.
  - Any state→IDLE when en=0. The address is held, the timer clears, and no step is produced.
  - load=1 while en=1: the address becomes load_val and the block enters BLANK with a fresh BLANK count. step and wrap stay 0. load beats a natural advance on the same edge.
  - load=1 while en=0: the address becomes load_val and the block stays in IDLE.
- dir is sampled only at the advance edge; changing dir mid-dwell affects the next advance.
- The address only changes on edges that leave ACTIVE or that apply a load, so the address never changes while the decoder is enabled.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency from inputs:
  - en rise to first ACTIVE cycle: 1 cycle.
  - en fall to IDLE outputs: 1 cycle.
  - load to new address on C/B/A: 1 cycle.
- Steady-state period per address is DIV+BLANK cycles; a full sweep is 8×(DIV+BLANK) cycles.
- step and wrap are high only in the first BLANK cycle after an advance.
- rst asserted mid-dwell or mid-blank returns every output to its reset value on the next edge, regardless of en or load.

## Structure
- Shared package/include `scan_pkg` holds:
  - the state encoding (IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2);
  - the enable triplets for each state as {G,G2A,G2B} constants;
  - the address width 3.
- One sub-module, `scan_timer`:
  - a loadable down-counter sized clog2(256);
  - loaded with DIV-1 or BLANK-1 on state entry;
  - asserts a `done` flag at zero.
- The top level holds the FSM, the address register and the output registers.

## Test plan
- Reset behaviour: DIV=4, BLANK=1, rst high for 3 cycles, en=1 → {C,B,A}=000, G/G2A/G2B=0/1/1 throughout reset. The first ACTIVE cycle occurs 1 cycle after rst falls.
- Up sweep: same configuration, en=1 → addresses 0..7 each dwell 4 cycles, separated by 1 blank cycle. step repeats every 5 cycles. wrap=1 exactly once per 40 cycles, at the 7→0 advance.
- Down sweep: dir=1 from address 2 → sequence 2,1,0,7,6. wrap is pulsed at the 0→7 advance.
- Load with conflict: load=1, load_val=5 on the same edge the 4-cycle dwell of address 3 completes → next cycle address 5 in BLANK with step=0. Then ACTIVE at 5 for 4 cycles, then advance to 6.
- Enable gating: en drops mid-ACTIVE at address 4 → IDLE next cycle with G=0, address held at 4. en rises → ACTIVE at 4 with a full 4-cycle dwell.
- Decoder integration: connect to `decoder_3_8` with DIV=2, BLANK=2 → Y=8'hFF during every blank and IDLE cycle. Exactly one Y bit is low during ACTIVE, and its index matches {C,B,A}.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan address generator: state encoding,
// decoder enable triplets per state, and the address/timer widths.
package scan_pkg;

    localparam int ADDR_W  = 3;
    // Wide enough to hold a reload value of 255 (dwell or blank of 256 cycles)
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    // Decoder enables packed as {G, G2A, G2B}
    localparam logic [2:0] EN_IDLE   = 3'b011;
    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam logic [2:0] EN_BLANK  = 3'b110;

    function automatic logic [2:0] enablesFor(input state_t s);
        logic [2:0] triplet;
        triplet = EN_IDLE;
        case (s)
            ST_ACTIVE: triplet = EN_ACTIVE;
            ST_BLANK:  triplet = EN_BLANK;
            default:   triplet = EN_IDLE;
        endcase
        return triplet;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter used to time the dwell and blanking phases.
// It is loaded with (length-1) on phase entry and reports done at zero,
// so a phase lasts exactly length cycles.
module scan_timer
    import scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_loadVal,
    input  logic               i_clear,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // Clear wins over load; otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/scan_addr_gen.sv
// Scan address generator for a 74138-style 3-8 decoder. Steps the select
// address through all eight outputs, holding each for DIV cycles with the
// decoder enabled and separating dwells with BLANK disabled cycles so the
// address only ever moves while the decoder is off.
module scan_addr_gen
    import scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic              C,
    output logic              B,
    output logic              A,
    output logic              G,
    output logic              G2A,
    output logic              G2B,
    output logic              step,
    output logic              wrap
);

    localparam logic [TIMER_W-1:0] DIV_RELOAD   = TIMER_W'(DIV - 1);
    localparam logic [TIMER_W-1:0] BLANK_RELOAD = TIMER_W'(BLANK - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_nextAddr;
    logic                w_advance;

    logic                w_timerLoad;
    logic                w_timerClear;
    logic [TIMER_W-1:0]  w_timerVal;
    logic                w_timerDone;

    logic [2:0]          w_enables;
    logic                w_step;
    logic                w_wrap;
    logic [2:0]          r_enables;
    logic                r_step;
    logic                r_wrap;

    scan_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_timerLoad),
        .i_loadVal (w_timerVal),
        .i_clear   (w_timerClear),
        .o_done    (w_timerDone)
    );

    // State and address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_nextState;
            r_addr  <= w_nextAddr;
        end
    end

    // Next state, next address and timer control; load outranks en, en outranks the timer
    always_comb begin
        w_nextState  = r_state;
        w_nextAddr   = r_addr;
        w_advance    = 1'b0;
        w_timerLoad  = 1'b0;
        w_timerClear = 1'b0;
        w_timerVal   = DIV_RELOAD;
        if (load) begin
            w_nextAddr = load_val;
            if (en) begin
                w_nextState = ST_BLANK;
                w_timerLoad = 1'b1;
                w_timerVal  = BLANK_RELOAD;
            end else begin
                w_nextState  = ST_IDLE;
                w_timerClear = 1'b1;
            end
        end else if (!en) begin
            w_nextState  = ST_IDLE;
            w_timerClear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState = ST_ACTIVE;
                    w_timerLoad = 1'b1;
                    w_timerVal  = DIV_RELOAD;
                end
                ST_ACTIVE: begin
                    if (w_timerDone) begin
                        w_nextState = ST_BLANK;
                        w_advance   = 1'b1;
                        w_nextAddr  = dir ? (r_addr - 1'b1) : (r_addr + 1'b1);
                        w_timerLoad = 1'b1;
                        w_timerVal  = BLANK_RELOAD;
                    end
                end
                ST_BLANK: begin
                    if (w_timerDone) begin
                        w_nextState = ST_ACTIVE;
                        w_timerLoad = 1'b1;
                        w_timerVal  = DIV_RELOAD;
                    end
                end
                default: begin
                    w_nextState  = ST_IDLE;
                    w_timerClear = 1'b1;
                end
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        w_enables = enablesFor(w_nextState);
        w_step    = w_advance;
        w_wrap    = w_advance && (dir ? (r_addr == '0) : (r_addr == '1));
    end

    // Output registers so nothing reaches the pins combinationally from inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enables <= EN_IDLE;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_enables <= w_enables;
            r_step    <= w_step;
            r_wrap    <= w_wrap;
        end
    end

    assign {C, B, A}     = r_addr;
    assign {G, G2A, G2B} = r_enables;
    assign step          = r_step;
    assign wrap          = r_wrap;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen: the driver applies inputs on the falling
// edge and queues the outputs a phase-level reference model predicts for the
// next rising edge; an independent monitor pops and compares after each edge.
module tb_scan_addr_gen;

    localparam int TDIV   = 4;
    localparam int TBLANK = 1;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic       C, B, A, G, G2A, G2B, step, wrap;

    typedef struct packed {
        logic [2:0] addr;
        logic [2:0] en3;
        logic       step;
        logic       wrap;
    } exp_t;

    typedef enum int {PH_IDLE, PH_ON, PH_GAP} phase_t;

    exp_t   expQ[$];
    int     errors = 0;
    int     checks = 0;

    phase_t mPhase   = PH_IDLE;
    int     mElapsed = 0;
    int     mAddr    = 0;
    logic   mStep    = 1'b0;
    logic   mWrap    = 1'b0;
    logic   curDir   = 1'b0;

    scan_addr_gen #(.DIV(TDIV), .BLANK(TBLANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .C        (C),
        .B        (B),
        .A        (A),
        .G        (G),
        .G2A      (G2A),
        .G2B      (G2B),
        .step     (step),
        .wrap     (wrap)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour: phases measured in elapsed cycles against DIV/BLANK
    function automatic void modelEdge(input logic iRst, input logic iEn, input logic iDir,
                                      input logic iLoad, input logic [2:0] iLv);
        mStep = 1'b0;
        mWrap = 1'b0;
        if (iRst) begin
            mPhase = PH_IDLE; mAddr = 0; mElapsed = 0;
        end else if (iLoad) begin
            mAddr    = int'(iLv);
            mPhase   = iEn ? PH_GAP : PH_IDLE;
            mElapsed = 0;
        end else if (!iEn) begin
            mPhase = PH_IDLE; mElapsed = 0;
        end else if (mPhase == PH_IDLE) begin
            mPhase = PH_ON; mElapsed = 0;
        end else if (mPhase == PH_ON) begin
            if (mElapsed + 1 == TDIV) begin
                mStep = 1'b1;
                if (iDir) begin
                    mWrap = (mAddr == 0);
                    mAddr = (mAddr + 7) % 8;
                end else begin
                    mWrap = (mAddr == 7);
                    mAddr = (mAddr + 1) % 8;
                end
                mPhase = PH_GAP; mElapsed = 0;
            end else begin
                mElapsed++;
            end
        end else begin
            if (mElapsed + 1 == TBLANK) begin
                mPhase = PH_ON; mElapsed = 0;
            end else begin
                mElapsed++;
            end
        end
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        e.addr = 3'(mAddr);
        case (mPhase)
            PH_ON:   e.en3 = 3'b100;
            PH_GAP:  e.en3 = 3'b110;
            default: e.en3 = 3'b011;
        endcase
        e.step = mStep;
        e.wrap = mWrap;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the predicted response
    task automatic applyStimulus(input logic iRst, input logic iEn, input logic iDir,
                                 input logic iLoad, input logic [2:0] iLv);
        @(negedge clk);
        rst      = iRst;
        en       = iEn;
        dir      = iDir;
        load     = iLoad;
        load_val = iLv;
        modelEdge(iRst, iEn, iDir, iLoad, iLv);
        expQ.push_back(modelOutputs());
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({C, B, A} !== e.addr) begin
            errors++;
            $display("[TB] FAIL addr: got %b expected %b at %0t", {C, B, A}, e.addr, $time);
        end
        checks++;
        if ({G, G2A, G2B} !== e.en3) begin
            errors++;
            $display("[TB] FAIL enables: got %b expected %b at %0t", {G, G2A, G2B}, e.en3, $time);
        end
        checks++;
        if (step !== e.step) begin
            errors++;
            $display("[TB] FAIL step: got %b expected %b at %0t", step, e.step, $time);
        end
        checks++;
        if (wrap !== e.wrap) begin
            errors++;
            $display("[TB] FAIL wrap: got %b expected %b at %0t", wrap, e.wrap, $time);
        end
    endtask

    // Monitor: compare one queued expectation shortly after every rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic runCycles(input int n, input logic iEn, input logic iDir);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, iEn, iDir, 1'b0, 3'd0);
    endtask

    task automatic reportTimeout(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected condition within 100 cycles", what);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        rst = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = 3'd0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        runCycles(45, 1'b1, 1'b0);

        // Down sweep from address 2
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
        runCycles(30, 1'b1, 1'b1);

        // Load colliding with the end of the dwell at address 3
        for (int i = 0; i < 100 && !(mPhase == PH_ON && mElapsed == TDIV - 1 && mAddr == 3); i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        if (mPhase == PH_ON && mElapsed == TDIV - 1 && mAddr == 3)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
        else
            reportTimeout("loadConflict");
        runCycles(12, 1'b1, 1'b0);

        // Enable dropped mid-dwell at address 4
        for (int i = 0; i < 100 && !(mPhase == PH_ON && mElapsed == 1 && mAddr == 4); i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        if (!(mPhase == PH_ON && mElapsed == 1 && mAddr == 4)) reportTimeout("enableGate");
        runCycles(3, 1'b0, 1'b0);
        runCycles(8, 1'b1, 1'b0);

        // Load while disabled stays idle
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        runCycles(2, 1'b0, 1'b0);
        runCycles(6, 1'b1, 1'b0);

        // Reset asserted mid-dwell with en and load both active
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
        runCycles(4, 1'b1, 1'b0);

        // Randomized traffic; direction is sticky so sweeps develop
        curDir = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) curDir = ~curDir;
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), curDir,
                          ($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)));
        end

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
